// File: rtl/rm_pkg.sv
// Shared types and constants for the Simple RISC Machine datapath.
// Holds datapath sizing, write-back source encodings and the status-flag layout.
package rm_pkg;

    localparam int DW   = 16;
    localparam int NREG = 8;
    localparam int AW   = $clog2(NREG);

    typedef logic [DW-1:0] word_t;
    typedef logic [AW-1:0] ridx_t;

    typedef enum logic [1:0] {
        VSEL_C     = 2'b00,
        VSEL_PC    = 2'b01,
        VSEL_IMM   = 2'b10,
        VSEL_MDATA = 2'b11
    } vsel_e;

    typedef struct packed {
        logic z;
        logic n;
        logic v;
    } status_t;

endpackage

// File: rtl/alu_writeback_if.sv
// Controller-to-write-back bundle: ALU result/flags, control strobes, mux sources and read port.
// The controller is the master; the write-back stage is the slave.
interface alu_writeback_if;
    import rm_pkg::*;

    word_t       alu_out;
    logic        Z;
    logic        N;
    logic        V;
    logic        loadc;
    logic        loads;
    logic        write;
    ridx_t       writenum;
    vsel_e       vsel;
    logic [7:0]  PC;
    word_t       sximm8;
    word_t       mdata;
    ridx_t       readnum;

    word_t       C;
    logic        Z_out;
    logic        N_out;
    logic        V_out;
    word_t       read_data;

    modport master (
        output alu_out, Z, N, V, loadc, loads, write, writenum, vsel,
               PC, sximm8, mdata, readnum,
        input  C, Z_out, N_out, V_out, read_data
    );

    modport slave (
        input  alu_out, Z, N, V, loadc, loads, write, writenum, vsel,
               PC, sximm8, mdata, readnum,
        output C, Z_out, N_out, V_out, read_data
    );

endinterface

// File: rtl/alu_writeback_regfile.sv
// 8 x 16 register file: one synchronous write port, one asynchronous read port.
// Synchronous clear on reset; reads of the register being written return the old value.
module regfile
    import rm_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  we_i,
    input  ridx_t waddr_i,
    input  word_t wdata_i,
    input  ridx_t raddr_i,
    output word_t rdata_o
);

    word_t mem_q [NREG];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // No write bypass: the read sees only committed state.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_writeback.sv
// Write-back stage: C register, status register, 4:1 source mux and the register file.
// C/status update one edge after their load strobes; register writes become readable after the edge.
module alu_writeback
    import rm_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    alu_writeback_if.slave   wb
);

    word_t   c_q, c_d;
    status_t status_q, status_d;
    word_t   wdata;

    always_comb begin
        c_d = c_q;
        if (wb.loadc) begin
            c_d = wb.alu_out;
        end
    end

    always_comb begin
        status_d = status_q;
        if (wb.loads) begin
            status_d = '{z: wb.Z, n: wb.N, v: wb.V};
        end
    end

    // C source uses c_q so a same-edge loadc writes back the pre-update value.
    always_comb begin
        wdata = c_q;
        unique case (wb.vsel)
            VSEL_C:     wdata = c_q;
            VSEL_PC:    wdata = {8'h00, wb.PC};
            VSEL_IMM:   wdata = wb.sximm8;
            VSEL_MDATA: wdata = wb.mdata;
            default:    wdata = c_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c_q      <= '0;
            status_q <= '0;
        end else begin
            c_q      <= c_d;
            status_q <= status_d;
        end
    end

    regfile u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we_i    (wb.write),
        .waddr_i (wb.writenum),
        .wdata_i (wdata),
        .raddr_i (wb.readnum),
        .rdata_o (wb.read_data)
    );

    assign wb.C     = c_q;
    assign wb.Z_out = status_q.z;
    assign wb.N_out = status_q.n;
    assign wb.V_out = status_q.v;

endmodule
